// File: rtl/incoming_request_buffer.sv
// AR-channel ingress buffer: tags each accepted read request from a free pool,
// queues it in a FIFO and presents it downstream through a registered output stage.
module incoming_request_buffer #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int TAG_WIDTH  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_ar_valid,
  output logic                  in_ar_ready,
  input  logic [ID_WIDTH-1:0]   in_ar_id,
  input  logic [ADDR_WIDTH-1:0] in_ar_addr,
  input  logic [LEN_WIDTH-1:0]  in_ar_len,
  output logic                  out_ar_valid,
  input  logic                  out_ar_ready,
  output logic [ID_WIDTH-1:0]   out_ar_id,
  output logic [ADDR_WIDTH-1:0] out_ar_addr,
  output logic [LEN_WIDTH-1:0]  out_ar_len,
  output logic [TAG_WIDTH-1:0]  out_ar_tagid,
  input  logic                  rel_valid,
  input  logic [TAG_WIDTH-1:0]  rel_tagid,
  output logic [TAG_WIDTH:0]    tags_free,
  output logic                  err_dbl_free
);

  localparam int NUM_TAGS = 1 << TAG_WIDTH;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);

  logic [NUM_TAGS-1:0]   busy_q, busy_d;
  logic                  dblFree_q, dblFree_d;
  logic [TAG_WIDTH-1:0]  allocTag;
  logic [TAG_WIDTH:0]    freeCount;

  logic [ID_WIDTH-1:0]   memId   [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] memAddr [FIFO_DEPTH];
  logic [LEN_WIDTH-1:0]  memLen  [FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]  memTag  [FIFO_DEPTH];
  logic [PTR_W-1:0]      wrPtr_q, rdPtr_q;
  logic [PTR_W:0]        count_q, count_d;
  logic                  fifoFull, fifoEmpty, push, pop;

  logic                  outValid_q;
  logic [ID_WIDTH-1:0]   outId_q;
  logic [ADDR_WIDTH-1:0] outAddr_q;
  logic [LEN_WIDTH-1:0]  outLen_q;
  logic [TAG_WIDTH-1:0]  outTag_q;

  // Descending scan so the lowest-index free tag wins; also counts free tags.
  always_comb begin
    allocTag  = '0;
    freeCount = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy_q[i]) allocTag = TAG_WIDTH'(i);
      freeCount = freeCount + {{TAG_WIDTH{1'b0}}, ~busy_q[i]};
    end
  end

  assign fifoFull    = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign fifoEmpty   = (count_q == '0);
  assign in_ar_ready = !fifoFull && (freeCount != '0);
  assign push        = in_ar_valid && in_ar_ready;
  assign pop         = !fifoEmpty && (!outValid_q || out_ar_ready);

  // Release is judged against the pre-edge busy map, so a tag being allocated
  // this cycle still counts as free and releasing it flags a double free.
  always_comb begin
    busy_d    = busy_q;
    dblFree_d = dblFree_q;
    if (rel_valid) begin
      if (busy_q[rel_tagid]) busy_d[rel_tagid] = 1'b0;
      else                   dblFree_d = 1'b1;
    end
    if (push) busy_d[allocTag] = 1'b1;
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      dblFree_q <= 1'b0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
    end else begin
      busy_q    <= busy_d;
      dblFree_q <= dblFree_d;
      count_q   <= count_d;
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  // Storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      memId[wrPtr_q]   <= in_ar_id;
      memAddr[wrPtr_q] <= in_ar_addr;
      memLen[wrPtr_q]  <= in_ar_len;
      memTag[wrPtr_q]  <= allocTag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q <= 1'b0;
      outId_q    <= '0;
      outAddr_q  <= '0;
      outLen_q   <= '0;
      outTag_q   <= '0;
    end else if (pop) begin
      outValid_q <= 1'b1;
      outId_q    <= memId[rdPtr_q];
      outAddr_q  <= memAddr[rdPtr_q];
      outLen_q   <= memLen[rdPtr_q];
      outTag_q   <= memTag[rdPtr_q];
    end else if (outValid_q && out_ar_ready) begin
      outValid_q <= 1'b0;
    end
  end

  assign out_ar_valid = outValid_q;
  assign out_ar_id    = outId_q;
  assign out_ar_addr  = outAddr_q;
  assign out_ar_len   = outLen_q;
  assign out_ar_tagid = outTag_q;
  assign tags_free    = freeCount;
  assign err_dbl_free = dblFree_q;

endmodule

// File: tb/tb_incoming_request_buffer.sv
// Bench for incoming_request_buffer: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_incoming_request_buffer;

  localparam int ID_WIDTH   = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int LEN_WIDTH  = 8;
  localparam int TAG_WIDTH  = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int NUM_TAGS   = 1 << TAG_WIDTH;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  in_ar_valid = 1'b0;
  logic                  in_ar_ready;
  logic [ID_WIDTH-1:0]   in_ar_id = '0;
  logic [ADDR_WIDTH-1:0] in_ar_addr = '0;
  logic [LEN_WIDTH-1:0]  in_ar_len = '0;
  logic                  out_ar_valid;
  logic                  out_ar_ready = 1'b0;
  logic [ID_WIDTH-1:0]   out_ar_id;
  logic [ADDR_WIDTH-1:0] out_ar_addr;
  logic [LEN_WIDTH-1:0]  out_ar_len;
  logic [TAG_WIDTH-1:0]  out_ar_tagid;
  logic                  rel_valid = 1'b0;
  logic [TAG_WIDTH-1:0]  rel_tagid = '0;
  logic [TAG_WIDTH:0]    tags_free;
  logic                  err_dbl_free;

  incoming_request_buffer #(
    .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH),
    .TAG_WIDTH(TAG_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_ar_valid(in_ar_valid), .in_ar_ready(in_ar_ready),
    .in_ar_id(in_ar_id), .in_ar_addr(in_ar_addr), .in_ar_len(in_ar_len),
    .out_ar_valid(out_ar_valid), .out_ar_ready(out_ar_ready),
    .out_ar_id(out_ar_id), .out_ar_addr(out_ar_addr), .out_ar_len(out_ar_len),
    .out_ar_tagid(out_ar_tagid),
    .rel_valid(rel_valid), .rel_tagid(rel_tagid),
    .tags_free(tags_free), .err_dbl_free(err_dbl_free)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [TAG_WIDTH-1:0]  tag;
  } req_t;

  int    errors = 0;
  int    checks = 0;
  bit    checkEn = 0;

  req_t  mq[$];
  bit    mBusy [NUM_TAGS];
  bit    mErr = 0;
  bit    mOv = 0;
  req_t  mOut = '0;
  bit    mAccepted = 0;
  int    mAllocTag;
  bit    mReady, mPop;

  function automatic int freeTags();
    int n = 0;
    foreach (mBusy[i]) if (!mBusy[i]) n++;
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the request queue holds everything accepted but not yet
  // presented; the output slot is refilled whenever it is empty or being taken.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      foreach (mBusy[i]) mBusy[i] = 0;
      mErr = 0;
      mOv = 0;
      mOut = '0;
      mAccepted = 0;
      checkEn = 1;
    end else begin
      mReady = (mq.size() < FIFO_DEPTH) && (freeTags() > 0);
      mAccepted = in_ar_valid && mReady;
      mAllocTag = -1;
      for (int i = 0; i < NUM_TAGS; i++) if (!mBusy[i] && mAllocTag < 0) mAllocTag = i;
      mPop = (mq.size() > 0) && (!mOv || out_ar_ready);
      if (rel_valid) begin
        if (mBusy[rel_tagid]) mBusy[rel_tagid] = 0;
        else mErr = 1;
      end
      if (mAccepted) mBusy[mAllocTag] = 1;
      if (mPop) begin
        mOut = mq.pop_front();
        mOv = 1;
      end else if (mOv && out_ar_ready) begin
        mOv = 0;
      end
      if (mAccepted)
        mq.push_back('{id: in_ar_id, addr: in_ar_addr, len: in_ar_len, tag: TAG_WIDTH'(mAllocTag)});
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("in_ar_ready", 64'(in_ar_ready),
                  64'((mq.size() < FIFO_DEPTH) && (freeTags() > 0)));
      checkOutput("out_ar_valid", 64'(out_ar_valid), 64'(mOv));
      checkOutput("out_ar_id", 64'(out_ar_id), 64'(mOut.id));
      checkOutput("out_ar_addr", 64'(out_ar_addr), 64'(mOut.addr));
      checkOutput("out_ar_len", 64'(out_ar_len), 64'(mOut.len));
      checkOutput("out_ar_tagid", 64'(out_ar_tagid), 64'(mOut.tag));
      checkOutput("tags_free", 64'(tags_free), 64'(freeTags()));
      checkOutput("err_dbl_free", 64'(err_dbl_free), 64'(mErr));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit v, input int id, input int addr, input int len,
                               input bit ordy, input bit rv, input int rt);
    in_ar_valid  = v;
    in_ar_id     = ID_WIDTH'(id);
    in_ar_addr   = ADDR_WIDTH'(addr);
    in_ar_len    = LEN_WIDTH'(len);
    out_ar_ready = ordy;
    rel_valid    = rv;
    rel_tagid    = TAG_WIDTH'(rt);
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    rst = 1;
    cycle();
    rst = 0;
  endtask

  int n;
  bit hold;
  int busyList[$];

  initial begin
    // Test 1: single request latency and first tag
    doReset();
    @(negedge clk);
    checkOutput("t1_reset_valid", 64'(out_ar_valid), 64'd0);
    checkOutput("t1_reset_tags_free", 64'(tags_free), 64'd16);
    checkOutput("t1_reset_ready", 64'(in_ar_ready), 64'd1);
    applyStimulus(1, 3, 'h100, 7, 1, 0, 0);
    cycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("t1_valid_after_E", 64'(out_ar_valid), 64'd0);
    checkOutput("t1_tags_free", 64'(tags_free), 64'd15);
    cycle();
    @(negedge clk);
    checkOutput("t1_valid_after_E1", 64'(out_ar_valid), 64'd1);
    checkOutput("t1_tagid", 64'(out_ar_tagid), 64'd0);
    checkOutput("t1_addr", 64'(out_ar_addr), 64'h100);
    checkOutput("t1_len", 64'(out_ar_len), 64'd7);

    // Test 2: exhaust all tags, then a release of tag 5 unblocks the 17th
    doReset();
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1, k, 'h1000 + k, k, 1, 0, 0);
      cycle();
    end
    applyStimulus(1, 1, 'h2000, 1, 1, 0, 0);
    cycle();
    cycle();
    @(negedge clk);
    checkOutput("t2_ready_no_tags", 64'(in_ar_ready), 64'd0);
    checkOutput("t2_tags_free_zero", 64'(tags_free), 64'd0);
    applyStimulus(1, 1, 'h2000, 1, 1, 1, 5);
    cycle();
    applyStimulus(1, 1, 'h2000, 1, 1, 0, 0);
    n = 0;
    while (!mAccepted && n < 10) begin
      cycle();
      n++;
    end
    checkOutput("t2_17th_accepted", 64'(mAccepted), 64'd1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    cycle();
    @(negedge clk);
    checkOutput("t2_17th_tag", 64'(out_ar_tagid), 64'd5);
    checkOutput("t2_17th_addr", 64'(out_ar_addr), 64'h2000);

    // Test 3: stalled downstream fills FIFO plus the output register
    doReset();
    n = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1, k, 'h3000 + 4 * k, k, 0, 0, 0);
      cycle();
      if (!mAccepted) break;
      n++;
    end
    checkOutput("t3_accepted", 64'(n), 64'd9);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t3_ready_full", 64'(in_ar_ready), 64'd0);
    for (int k = 0; k < 4; k++) cycle();
    @(negedge clk);
    checkOutput("t3_stable_addr", 64'(out_ar_addr), 64'h3000);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 12; k++) cycle();

    // Test 4: allocation and release in the same cycle
    doReset();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, k, 'h4000 + k, 0, 1, 0, 0);
      cycle();
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    cycle();
    @(negedge clk);
    checkOutput("t4_tags_before", 64'(tags_free), 64'd13);
    applyStimulus(1, 7, 'h4100, 0, 1, 1, 2);
    cycle();
    applyStimulus(1, 8, 'h4200, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("t4_tags_after", 64'(tags_free), 64'd13);
    cycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("t4_same_cycle_tag", 64'(out_ar_tagid), 64'd3);
    cycle();
    @(negedge clk);
    checkOutput("t4_next_tag", 64'(out_ar_tagid), 64'd2);

    // Test 5: double free is ignored and sticky until reset
    doReset();
    applyStimulus(0, 0, 0, 0, 1, 1, 9);
    cycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("t5_err_set", 64'(err_dbl_free), 64'd1);
    checkOutput("t5_tags_free", 64'(tags_free), 64'd16);
    for (int k = 0; k < 3; k++) cycle();
    @(negedge clk);
    checkOutput("t5_err_sticky", 64'(err_dbl_free), 64'd1);
    doReset();
    @(negedge clk);
    checkOutput("t5_err_cleared", 64'(err_dbl_free), 64'd0);

    // Test 6: reset with requests queued and output valid
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, k, 'h6000 + k, 0, 0, 0, 0);
      cycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t6_valid_before", 64'(out_ar_valid), 64'd1);
    doReset();
    @(negedge clk);
    checkOutput("t6_valid_after", 64'(out_ar_valid), 64'd0);
    checkOutput("t6_tags_free", 64'(tags_free), 64'd16);
    checkOutput("t6_ready", 64'(in_ar_ready), 64'd1);

    // Randomized traffic: master holds a request until accepted
    doReset();
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!(hold && in_ar_valid && !mAccepted)) begin
        in_ar_valid = ($urandom_range(0, 2) != 0);
        in_ar_id    = ID_WIDTH'($urandom);
        in_ar_addr  = $urandom;
        in_ar_len   = LEN_WIDTH'($urandom);
      end
      hold = 1;
      out_ar_ready = ($urandom_range(0, 3) != 0);
      busyList.delete();
      foreach (mBusy[i]) if (mBusy[i]) busyList.push_back(i);
      rel_valid = 0;
      if ($urandom_range(0, 99) < 3) begin
        rel_valid = 1;
        rel_tagid = TAG_WIDTH'($urandom);
      end else if (busyList.size() > 0 && $urandom_range(0, 99) < 35) begin
        rel_valid = 1;
        rel_tagid = TAG_WIDTH'(busyList[$urandom_range(0, busyList.size() - 1)]);
      end
      cycle();
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 12; k++) cycle();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
